// File: rtl/fault_detect_seq_pkg.sv
// Shared definitions for the 2:1 mux fault-detection sequencer.
package fault_detect_seq_pkg;

    // Vector index width: 3 stimulus bits -> 8 vectors.
    localparam int unsigned VEC_W   = 3;
    // Number of observable nets in the mux netlist.
    localparam int unsigned NET_W   = 9;
    // Width of the settle counter and mismatch counter.
    localparam int unsigned CNT_W   = 4;
    // Number of vectors in a full test.
    localparam int unsigned NUM_VEC = 1 << VEC_W;

    // Default observation mask: only the primary output (net 8).
    localparam logic [NET_W-1:0] OBS_MASK_DEFAULT = 9'h100;

    // Sequencer states.
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_APPLY   = 3'd1;
    localparam logic [2:0] ST_SETTLE  = 3'd2;
    localparam logic [2:0] ST_COMPARE = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    // Stimulus bundle; field order matches vec[2:0] = {S, I1, I0}.
    typedef struct packed {
        logic s;
        logic i1;
        logic i0;
    } stim_t;

    // Map a vector index onto the stimulus pins.
    function automatic stim_t f_vec_to_stim(input logic [VEC_W-1:0] vec);
        stim_t stim;
        stim.s  = vec[2];
        stim.i1 = vec[1];
        stim.i0 = vec[0];
        return stim;
    endfunction

    // A fault is exposed when any observed net differs between the two instances.
    function automatic logic f_mismatch(input logic [NET_W-1:0] good,
                                        input logic [NET_W-1:0] fault,
                                        input logic [NET_W-1:0] mask);
        return |((good ^ fault) & mask);
    endfunction

endpackage

// File: rtl/fault_detect_seq_settle_counter.sv
// Settle counter: loadable down-counter with a zero flag, stops at zero.
module fault_detect_seq_settle_counter
    import fault_detect_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_count;

    // Load has priority over decrement; decrement never wraps below zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/fault_detect_seq.sv
// Fault-detection sequencer: walks all 8 input vectors of a 2:1 mux pair,
// compares observed nets of the golden and faulty instances, and reports
// which vectors exposed the fault.
module fault_detect_seq
    import fault_detect_seq_pkg::*;
#(
    parameter int unsigned        SETTLE_CYC = 1,
    parameter logic [NET_W-1:0]   OBS_MASK   = OBS_MASK_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [NET_W-1:0]   good_out,
    input  logic [NET_W-1:0]   fault_out,
    output logic               S,
    output logic               I0,
    output logic               I1,
    output logic               busy,
    output logic               done,
    output logic               detected,
    output logic [VEC_W-1:0]   first_vec,
    output logic [NUM_VEC-1:0] detect_map,
    output logic [CNT_W-1:0]   mismatch_count
);

    localparam logic [CNT_W-1:0] LP_SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [VEC_W-1:0] LP_LAST_VEC    = VEC_W'(NUM_VEC - 1);

    logic [2:0]         r_state;
    logic [2:0]         w_state_next;
    logic [VEC_W-1:0]   r_vec;
    logic [VEC_W-1:0]   w_vec_next;
    stim_t              r_stim;
    stim_t              w_stim_next;
    logic               r_busy;
    logic               r_done;
    logic               r_detected;
    logic [VEC_W-1:0]   r_first_vec;
    logic [NUM_VEC-1:0] r_detect_map;
    logic [CNT_W-1:0]   r_mismatch_count;

    logic               w_accept;
    logic               w_counter_load;
    logic               w_counter_dec;
    logic               w_settle_zero;
    logic               w_mismatch;
    logic               w_record;
    logic               w_stim_active;

    // A start is only honoured from IDLE; DONE returns to IDLE unconditionally.
    assign w_accept       = (r_state == ST_IDLE) && start;
    assign w_counter_load = (r_state == ST_APPLY);
    assign w_counter_dec  = (r_state == ST_SETTLE);
    assign w_mismatch     = f_mismatch(good_out, fault_out, OBS_MASK);
    assign w_record       = (r_state == ST_COMPARE) && w_mismatch;

    fault_detect_seq_settle_counter u_settle_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_counter_load),
        .i_load_val (LP_SETTLE_LOAD),
        .i_dec      (w_counter_dec),
        .o_zero     (w_settle_zero)
    );

    // Next-state and next-vector selection.
    always_comb begin
        w_state_next = r_state;
        w_vec_next   = r_vec;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = ST_APPLY;
                    w_vec_next   = '0;
                end
            end
            ST_APPLY: begin
                w_state_next = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (w_settle_zero) begin
                    w_state_next = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                if (r_vec == LP_LAST_VEC) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_APPLY;
                    w_vec_next   = r_vec + VEC_W'(1);
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
                w_vec_next   = '0;
            end
        endcase
    end

    // Stimulus is driven only while a vector is in flight, otherwise parked at 0.
    always_comb begin
        w_stim_active = (w_state_next == ST_APPLY)  ||
                        (w_state_next == ST_SETTLE) ||
                        (w_state_next == ST_COMPARE);
        w_stim_next   = w_stim_active ? f_vec_to_stim(w_vec_next) : '0;
    end

    // Sequencer state, vector index and registered control outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_vec   <= '0;
            r_stim  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_vec   <= w_vec_next;
            r_stim  <= w_stim_next;
            r_busy  <= (w_state_next != ST_IDLE);
            r_done  <= (w_state_next == ST_DONE);
        end
    end

    // Result registers: cleared on an accepted start, updated on each exposing vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_detected       <= 1'b0;
            r_first_vec      <= '0;
            r_detect_map     <= '0;
            r_mismatch_count <= '0;
        end else if (w_accept) begin
            r_detected       <= 1'b0;
            r_first_vec      <= '0;
            r_detect_map     <= '0;
            r_mismatch_count <= '0;
        end else if (w_record) begin
            r_detected          <= 1'b1;
            r_detect_map[r_vec] <= 1'b1;
            // Each vector is compared once, so the count cannot exceed 8.
            r_mismatch_count    <= r_mismatch_count + CNT_W'(1);
            if (!r_detected) begin
                r_first_vec <= r_vec;
            end
        end
    end

    assign S              = r_stim.s;
    assign I1             = r_stim.i1;
    assign I0             = r_stim.i0;
    assign busy           = r_busy;
    assign done           = r_done;
    assign detected       = r_detected;
    assign first_vec      = r_first_vec;
    assign detect_map     = r_detect_map;
    assign mismatch_count = r_mismatch_count;

endmodule

// File: tb/tb_fault_detect_seq.sv
// Testbench for fault_detect_seq: three instances with different parameters,
// each driving a behavioural golden/faulty 2:1 mux netlist pair.
module tb_fault_detect_seq;

    localparam int SC [3] = '{1, 3, 1};

    // Fault modes for the behavioural netlist.
    localparam int F_NONE    = 0;
    localparam int F_N7_SA0  = 1;
    localparam int F_N8_SA0  = 2;
    localparam int F_N5_INV  = 3;

    typedef struct {
        logic [7:0] map;
        logic [2:0] first;
        logic [3:0] cnt;
        logic       det;
        int         cyc;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       start_r  [3];
    logic       s_w      [3];
    logic       i0_w     [3];
    logic       i1_w     [3];
    logic       busy_w   [3];
    logic       done_w   [3];
    logic       det_w    [3];
    logic [2:0] first_w  [3];
    logic [7:0] map_w    [3];
    logic [3:0] cnt_w    [3];
    logic [8:0] good_w   [3];
    logic [8:0] fault_w  [3];
    int         fmode    [3];

    exp_t       exp_q    [3][$];
    exp_t       e;
    logic       prev_done [3];
    int         bidx      [3];
    int         cyc;
    int         n_chk;
    int         n_fail;

    // Gate-level 2:1 mux nets: n0=S n1=I0 n2=I1 n3=~S n4=I0 branch n5=I1 branch
    // n6=n5&S n7=n4&n3 n8=n6|n7 (primary output).
    function automatic logic [8:0] f_nets(input logic s, input logic i0, input logic i1,
                                          input int mode);
        logic [8:0] n;
        n[0] = s;
        n[1] = i0;
        n[2] = i1;
        n[3] = ~s;
        n[4] = i0;
        n[5] = (mode == F_N5_INV) ? ~i1 : i1;
        n[6] = n[5] & s;
        n[7] = (mode == F_N7_SA0) ? 1'b0 : (n[4] & n[3]);
        n[8] = (mode == F_N8_SA0) ? 1'b0 : (n[6] | n[7]);
        return n;
    endfunction

    always_comb begin
        for (int g = 0; g < 3; g++) begin
            good_w[g]  = f_nets(s_w[g], i0_w[g], i1_w[g], F_NONE);
            fault_w[g] = f_nets(s_w[g], i0_w[g], i1_w[g], fmode[g]);
        end
    end

    fault_detect_seq #(.SETTLE_CYC(1), .OBS_MASK(9'h100)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_r[0]),
        .good_out(good_w[0]), .fault_out(fault_w[0]),
        .S(s_w[0]), .I0(i0_w[0]), .I1(i1_w[0]), .busy(busy_w[0]), .done(done_w[0]),
        .detected(det_w[0]), .first_vec(first_w[0]), .detect_map(map_w[0]),
        .mismatch_count(cnt_w[0])
    );

    fault_detect_seq #(.SETTLE_CYC(3), .OBS_MASK(9'h1FF)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_r[1]),
        .good_out(good_w[1]), .fault_out(fault_w[1]),
        .S(s_w[1]), .I0(i0_w[1]), .I1(i1_w[1]), .busy(busy_w[1]), .done(done_w[1]),
        .detected(det_w[1]), .first_vec(first_w[1]), .detect_map(map_w[1]),
        .mismatch_count(cnt_w[1])
    );

    fault_detect_seq #(.SETTLE_CYC(1), .OBS_MASK(9'h000)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start_r[2]),
        .good_out(good_w[2]), .fault_out(fault_w[2]),
        .S(s_w[2]), .I0(i0_w[2]), .I1(i1_w[2]), .busy(busy_w[2]), .done(done_w[2]),
        .detected(det_w[2]), .first_vec(first_w[2]), .detect_map(map_w[2]),
        .mismatch_count(cnt_w[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input int g, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL dut%0d %s: got 0x%0h expected 0x%0h (cycle %0d)",
                     g, name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every done pulse and checks the stimulus walk.
    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (prev_done[g]) begin
                chk(g, "done_width", {31'd0, done_w[g]}, 32'd0);
                chk(g, "busy_after_done", {31'd0, busy_w[g]}, 32'd0);
            end
            prev_done[g] = done_w[g];
            if (done_w[g]) begin
                chk(g, "done_expected", (exp_q[g].size() != 0) ? 32'd1 : 32'd0, 32'd1);
                if (exp_q[g].size() != 0) begin
                    e = exp_q[g].pop_front();
                    chk(g, "detect_map", {24'd0, map_w[g]}, {24'd0, e.map});
                    chk(g, "first_vec", {29'd0, first_w[g]}, {29'd0, e.first});
                    chk(g, "mismatch_count", {28'd0, cnt_w[g]}, {28'd0, e.cnt});
                    chk(g, "detected", {31'd0, det_w[g]}, {31'd0, e.det});
                    chk(g, "done_cycle", cyc, e.cyc);
                    chk(g, "busy_at_done", {31'd0, busy_w[g]}, 32'd1);
                end
            end
            if (busy_w[g] && !done_w[g]) begin
                chk(g, "stim_vec", {29'd0, s_w[g], i1_w[g], i0_w[g]},
                    32'(bidx[g] / (SC[g] + 2)));
                bidx[g]++;
            end else begin
                bidx[g] = 0;
            end
        end
    end

    task automatic wait_idle(input int g);
        int k;
        k = 0;
        while (exp_q[g].size() != 0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk(g, "done_timeout", exp_q[g].size(), 0);
        exp_q[g].delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic run(input int g, input int mode, input logic [7:0] map,
                       input logic [2:0] first, input logic [3:0] cnt, input logic det);
        exp_t x;
        @(negedge clk);
        fmode[g] = mode;
        x.map = map; x.first = first; x.cnt = cnt; x.det = det;
        x.cyc = cyc + 8 * (SC[g] + 2) + 1;
        exp_q[g].push_back(x);
        start_r[g] = 1'b1;
        @(negedge clk);
        start_r[g] = 1'b0;
        wait_idle(g);
    endtask

    task automatic chk_all_zero(input int g, input string tag);
        chk(g, {tag, "_S_I1_I0"}, {29'd0, s_w[g], i1_w[g], i0_w[g]}, 32'd0);
        chk(g, {tag, "_busy_done"}, {30'd0, busy_w[g], done_w[g]}, 32'd0);
        chk(g, {tag, "_detected"}, {31'd0, det_w[g]}, 32'd0);
        chk(g, {tag, "_first_vec"}, {29'd0, first_w[g]}, 32'd0);
        chk(g, {tag, "_detect_map"}, {24'd0, map_w[g]}, 32'd0);
        chk(g, {tag, "_count"}, {28'd0, cnt_w[g]}, 32'd0);
    endtask

    initial begin
        exp_t x;
        n_chk  = 0;
        n_fail = 0;
        cyc    = 0;
        rst_n  = 1'b0;
        for (int g = 0; g < 3; g++) begin
            start_r[g]   = 1'b0;
            fmode[g]     = F_NONE;
            prev_done[g] = 1'b0;
            bidx[g]      = 0;
        end
        repeat (2) @(negedge clk);
        for (int g = 0; g < 3; g++) chk_all_zero(g, "reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Fault-free pair, then net 7 stuck-at-0, then primary output stuck-at-0.
        run(0, F_NONE,   8'h00, 3'd0, 4'd0, 1'b0);
        run(0, F_N7_SA0, 8'h0A, 3'd1, 4'd2, 1'b1);
        run(0, F_N8_SA0, 8'hCA, 3'd1, 4'd4, 1'b1);

        // Results hold in IDLE.
        repeat (10) @(negedge clk);
        chk(0, "hold_map", {24'd0, map_w[0]}, 32'h0CA);
        chk(0, "hold_count", {28'd0, cnt_w[0]}, 32'd4);
        chk(0, "hold_busy", {31'd0, busy_w[0]}, 32'd0);

        // Reset during vector 4 (APPLY of vec 4 is 13 cycles after the start cycle).
        @(negedge clk);
        fmode[0]   = F_N8_SA0;
        start_r[0] = 1'b1;
        @(negedge clk);
        start_r[0] = 1'b0;
        repeat (12) @(negedge clk);
        chk(0, "vec4_before_reset", {29'd0, s_w[0], i1_w[0], i0_w[0]}, 32'd4);
        #3 rst_n = 1'b0;
        #1 chk_all_zero(0, "midrun_reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk(0, "idle_after_reset", {31'd0, busy_w[0]}, 32'd0);
        run(0, F_N8_SA0, 8'hCA, 3'd1, 4'd4, 1'b1);

        // start held every cycle through the done cycle: one run only.
        @(negedge clk);
        fmode[0] = F_N7_SA0;
        x.map = 8'h0A; x.first = 3'd1; x.cnt = 4'd2; x.det = 1'b1; x.cyc = cyc + 25;
        exp_q[0].push_back(x);
        start_r[0] = 1'b1;
        repeat (25) @(negedge clk);
        start_r[0] = 1'b0;
        repeat (30) @(negedge clk);
        chk(0, "single_done_queue", exp_q[0].size(), 0);
        chk(0, "idle_after_restart_spam", {31'd0, busy_w[0]}, 32'd0);
        exp_q[0].delete();

        // Long settle, full mask, net 5 inverted: every vector exposes it.
        run(1, F_N5_INV, 8'hFF, 3'd0, 4'd8, 1'b1);
        // Empty mask: nothing is ever recorded.
        run(2, F_N8_SA0, 8'h00, 3'd0, 4'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no end expected end");
        $fatal(1, "watchdog");
    end

endmodule
